// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined WIDTH-bit ALU with valid/ready handshakes,
// registered result flags and a sticky carry for multi-word chained arithmetic.
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       select,
    input  logic             mode,
    input  logic             carry_in,
    input  logic             chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             compare,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);
    localparam int MSB = WIDTH - 1;

    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]       sel_q, sel_d;
    logic             mode_q, mode_d, cin_q, cin_d, chain_q, chain_d;
    logic             cout_q, cout_d, cmp_q, cmp_d, ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic             advance, accept, cin_eff;
    logic [WIDTH-1:0] x, y, logic_res;
    logic [WIDTH:0]   sum;

    assign advance  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = rst && (!s1_valid_q || advance);
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = accept ? 1'b1 : (advance ? 1'b0 : s1_valid_q);
        a_d        = accept ? in_a : a_q;
        b_d        = accept ? in_b : b_q;
        sel_d      = accept ? select : sel_q;
        mode_d     = accept ? mode : mode_q;
        cin_d      = accept ? carry_in : cin_q;
        chain_d    = accept ? chain : chain_q;
    end

    always_comb begin
        x = '0;
        y = '0;
        case (sel_q)
            4'd0:  begin x = a_q;          y = '0;          end
            4'd1:  begin x = a_q | b_q;    y = '0;          end
            4'd2:  begin x = a_q | ~b_q;   y = '0;          end
            4'd3:  begin x = '0;           y = '1;          end
            4'd4:  begin x = a_q;          y = a_q & ~b_q;  end
            4'd5:  begin x = a_q | b_q;    y = a_q & ~b_q;  end
            4'd6:  begin x = a_q;          y = ~b_q;        end
            4'd7:  begin x = a_q & ~b_q;   y = '1;          end
            4'd8:  begin x = a_q;          y = a_q & b_q;   end
            4'd9:  begin x = a_q;          y = b_q;         end
            4'd10: begin x = a_q | ~b_q;   y = a_q & b_q;   end
            4'd11: begin x = a_q & b_q;    y = '1;          end
            4'd12: begin x = a_q;          y = a_q;         end
            4'd13: begin x = a_q | b_q;    y = a_q;         end
            4'd14: begin x = a_q | ~b_q;   y = a_q;         end
            default: begin x = a_q;        y = '1;          end
        endcase
    end

    always_comb begin
        logic_res = '0;
        case (sel_q)
            4'd0:  logic_res = ~a_q;
            4'd1:  logic_res = ~(a_q | b_q);
            4'd2:  logic_res = ~a_q & b_q;
            4'd3:  logic_res = '0;
            4'd4:  logic_res = ~(a_q & b_q);
            4'd5:  logic_res = ~b_q;
            4'd6:  logic_res = a_q ^ b_q;
            4'd7:  logic_res = a_q & ~b_q;
            4'd8:  logic_res = ~a_q | b_q;
            4'd9:  logic_res = ~(a_q ^ b_q);
            4'd10: logic_res = b_q;
            4'd11: logic_res = a_q & b_q;
            4'd12: logic_res = '1;
            4'd13: logic_res = a_q | ~b_q;
            4'd14: logic_res = a_q | b_q;
            default: logic_res = a_q;
        endcase
    end

    // Sticky is read at the advance edge, so a chained op right behind its producer sees the fresh carry.
    always_comb begin
        cin_eff    = chain_q ? sticky_q : cin_q;
        sum        = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(cin_eff);
        res_d      = advance ? (mode_q ? logic_res : sum[MSB:0]) : res_q;
        cout_d     = advance ? (!mode_q && sum[WIDTH]) : cout_q;
        ovf_d      = advance ? (!mode_q && (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB])) : ovf_q;
        cmp_d      = advance ? (a_q == b_q) : cmp_q;
        sticky_d   = (advance && !mode_q) ? sum[WIDTH] : sticky_q;
        s2_valid_d = advance ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            mode_q     <= 1'b0;
            cin_q      <= 1'b0;
            chain_q    <= 1'b0;
            res_q      <= '0;
            cout_q     <= 1'b0;
            cmp_q      <= 1'b0;
            ovf_q      <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            cin_q      <= cin_d;
            chain_q    <= chain_d;
            res_q      <= res_d;
            cout_q     <= cout_d;
            cmp_q      <= cmp_d;
            ovf_q      <= ovf_d;
            sticky_q   <= sticky_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign alu_out   = res_q;
    assign carry_out = cout_q;
    assign compare   = cmp_q;
    assign zero      = s2_valid_q && (res_q == '0);
    assign negative  = res_q[MSB];
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scenarios plus randomized traffic checked against an
// arithmetic reference model of the pipelined ALU.
module tb_alu_pipe;
    localparam int W = 16;

    typedef struct packed {
        logic         in_ready;
        logic         out_valid;
        logic [W-1:0] alu_out;
        logic         carry_out;
        logic         compare;
        logic         zero;
        logic         negative;
        logic         overflow;
    } obs_t;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         cmp;
        logic         z;
        logic         n;
        logic         o;
    } exp_t;

    logic         clk = 0, rst = 0, in_valid = 0, mode = 0, carry_in = 0, chain = 0, out_ready = 0;
    logic [W-1:0] in_a = 0, in_b = 0;
    logic [3:0]   select = 0;
    logic         in_ready, out_valid, carry_out, compare, zero, negative, overflow;
    logic [W-1:0] alu_out;
    int           errs = 0, checks = 0;
    logic         msticky = 0;
    exp_t         q[$];

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .select(select), .mode(mode),
        .carry_in(carry_in), .chain(chain), .out_valid(out_valid),
        .out_ready(out_ready), .alu_out(alu_out), .carry_out(carry_out),
        .compare(compare), .zero(zero), .negative(negative), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] sel, input logic m, input logic cin);
        exp_t e;
        logic [W-1:0] x, y, ones;
        int s, sx, sy;
        ones = '1;
        e = '0;
        e.cmp = (a == b);
        if (m) begin
            case (sel)
                0: e.r = ~a;        1: e.r = ~(a | b);   2: e.r = ~a & b;    3: e.r = 0;
                4: e.r = ~(a & b);  5: e.r = ~b;         6: e.r = a ^ b;     7: e.r = a & ~b;
                8: e.r = ~a | b;    9: e.r = ~(a ^ b);   10: e.r = b;        11: e.r = a & b;
                12: e.r = ones;     13: e.r = a | ~b;    14: e.r = a | b;    default: e.r = a;
            endcase
        end else begin
            case (sel)
                0: begin x = a; y = 0; end               1: begin x = a | b; y = 0; end
                2: begin x = a | ~b; y = 0; end          3: begin x = 0; y = ones; end
                4: begin x = a; y = a & ~b; end          5: begin x = a | b; y = a & ~b; end
                6: begin x = a; y = ~b; end              7: begin x = a & ~b; y = ones; end
                8: begin x = a; y = a & b; end           9: begin x = a; y = b; end
                10: begin x = a | ~b; y = a & b; end     11: begin x = a & b; y = ones; end
                12: begin x = a; y = a; end              13: begin x = a | b; y = a; end
                14: begin x = a | ~b; y = a; end         default: begin x = a; y = ones; end
            endcase
            s = int'(x) + int'(y) + int'(cin);
            e.r = W'(s);
            e.c = (s >= (1 << W));
            sx = int'($signed(x));
            sy = int'($signed(y));
            s = sx + sy + int'(cin);
            e.o = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
        end
        e.z = (e.r == 0);
        e.n = e.r[W-1];
        return e;
    endfunction

    // Called at posedge+1: drives inputs, observes before the next edge, returns at posedge+1.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] sel, input logic m, input logic ci, input logic ch,
                        input logic rdy, output logic acc, output logic xf, output obs_t o);
        in_valid = v; in_a = a; in_b = b; select = sel; mode = m;
        carry_in = ci; chain = ch; out_ready = rdy;
        #1;
        o = '{in_ready, out_valid, alu_out, carry_out, compare, zero, negative, overflow};
        acc = v && in_ready;
        xf = out_valid && rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] sel,
                          input logic m, input logic ci, input logic ch, output obs_t o, output logic got);
        logic acc, xf;
        int n;
        got = 0; acc = 0; n = 0;
        while (!acc && n < 8) begin step(1, a, b, sel, m, ci, ch, 1, acc, xf, o); n++; end
        n = 0;
        while (!got && n < 8) begin step(0, a, b, sel, m, ci, ch, 1, acc, xf, o); got = o.out_valid; n++; end
    endtask

    task automatic do_reset;
        in_valid = 0;
        rst = 0;
        #2;
        rst = 1;
        msticky = 0;
        q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        in_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 0 || alu_out !== 0 || in_ready !== 0) begin
            errs++; $display("FAIL reset_outputs out_valid=%b alu_out=%h in_ready=%b expected 0 0 0", out_valid, alu_out, in_ready);
        end
        checks++;
        if ({carry_out, compare, zero, negative, overflow} !== 5'b0) begin
            errs++; $display("FAIL reset_flags got=%b expected 00000", {carry_out, compare, zero, negative, overflow});
        end
        in_valid = 0;
        rst = 1;
        #1;
        checks++;
        if (in_ready !== 1) begin errs++; $display("FAIL reset_release in_ready=%b expected 1", in_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add;
        logic acc, xf;
        obs_t o;
        step(1, 16'h1234, 16'h0001, 4'd9, 0, 0, 0, 1, acc, xf, o);
        checks++;
        if (acc !== 1) begin errs++; $display("FAIL add_accept got=%b expected 1", acc); end
        step(0, 0, 0, 0, 0, 0, 0, 1, acc, xf, o);
        checks++;
        if (o.out_valid !== 0) begin errs++; $display("FAIL add_early out_valid=%b expected 0", o.out_valid); end
        step(0, 0, 0, 0, 0, 0, 0, 1, acc, xf, o);
        checks++;
        if (o.out_valid !== 1 || o.alu_out !== 16'h1235 || o.carry_out !== 0 || o.zero !== 0) begin
            errs++; $display("FAIL add_result v=%b r=%h c=%b z=%b expected 1 1235 0 0", o.out_valid, o.alu_out, o.carry_out, o.zero);
        end
    endtask

    task automatic test_chain;
        logic acc1, acc2, xf;
        obs_t o;
        step(1, 16'hFFFF, 16'h0001, 4'd9, 0, 0, 0, 1, acc1, xf, o);
        step(1, 16'h0000, 16'h0000, 4'd9, 0, 0, 1, 1, acc2, xf, o);
        checks++;
        if (acc1 !== 1 || acc2 !== 1) begin errs++; $display("FAIL chain_accept got=%b%b expected 11", acc1, acc2); end
        step(0, 0, 0, 0, 0, 0, 0, 1, acc1, xf, o);
        checks++;
        if (o.out_valid !== 1 || o.alu_out !== 16'h0000 || o.carry_out !== 1 || o.zero !== 1) begin
            errs++; $display("FAIL chain_low v=%b r=%h c=%b z=%b expected 1 0000 1 1", o.out_valid, o.alu_out, o.carry_out, o.zero);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, acc1, xf, o);
        checks++;
        if (o.out_valid !== 1 || o.alu_out !== 16'h0001 || o.carry_out !== 0) begin
            errs++; $display("FAIL chain_high v=%b r=%h c=%b expected 1 0001 0", o.out_valid, o.alu_out, o.carry_out);
        end
    endtask

    task automatic test_overflow;
        obs_t o;
        logic got;
        run_op(16'h7FFF, 16'h0001, 4'd9, 0, 0, 0, o, got);
        checks++;
        if (!got || o.alu_out !== 16'h8000 || o.overflow !== 1 || o.negative !== 1 || o.carry_out !== 0) begin
            errs++; $display("FAIL ovf_add got=%b r=%h o=%b n=%b c=%b expected 1 8000 1 1 0", got, o.alu_out, o.overflow, o.negative, o.carry_out);
        end
        run_op(16'h0005, 16'h0003, 4'd6, 0, 1, 0, o, got);
        checks++;
        if (!got || o.alu_out !== 16'h0002 || o.carry_out !== 1 || o.overflow !== 0) begin
            errs++; $display("FAIL sub_cin got=%b r=%h c=%b o=%b expected 1 0002 1 0", got, o.alu_out, o.carry_out, o.overflow);
        end
    endtask

    task automatic test_logic_compare;
        obs_t o;
        logic got;
        run_op(16'hF0F0, 16'hFF00, 4'd6, 1, 1, 0, o, got);
        checks++;
        if (!got || o.alu_out !== 16'h0FF0 || o.carry_out !== 0 || o.compare !== 0 || o.overflow !== 0) begin
            errs++; $display("FAIL logic_xor got=%b r=%h c=%b cmp=%b o=%b expected 1 0ff0 0 0 0", got, o.alu_out, o.carry_out, o.compare, o.overflow);
        end
        run_op(16'hAAAA, 16'hAAAA, 4'd15, 1, 0, 0, o, got);
        checks++;
        if (!got || o.alu_out !== 16'hAAAA || o.compare !== 1 || o.negative !== 1) begin
            errs++; $display("FAIL logic_pass got=%b r=%h cmp=%b n=%b expected 1 aaaa 1 1", got, o.alu_out, o.compare, o.negative);
        end
    endtask

    task automatic test_backpressure;
        logic acc1, acc2, acc, xf;
        obs_t o, o2;
        logic got;
        step(1, 16'd1, 16'd2, 4'd9, 0, 0, 0, 0, acc1, xf, o);
        step(1, 16'd10, 16'd20, 4'd9, 0, 0, 0, 0, acc2, xf, o);
        step(1, 16'h100, 16'h1, 4'd9, 0, 0, 0, 0, acc, xf, o);
        checks++;
        if (acc1 !== 1 || acc2 !== 1 || acc !== 0 || o.in_ready !== 0) begin
            errs++; $display("FAIL bp_accept got=%b%b%b in_ready=%b expected 110 0", acc1, acc2, acc, o.in_ready);
        end
        checks++;
        if (o.out_valid !== 1 || o.alu_out !== 16'd3) begin
            errs++; $display("FAIL bp_head v=%b r=%h expected 1 0003", o.out_valid, o.alu_out);
        end
        repeat (2) begin
            step(1, 16'h100, 16'h1, 4'd9, 0, 0, 0, 0, acc, xf, o2);
            checks++;
            if (o2 !== o || acc !== 0) begin
                errs++; $display("FAIL bp_stable got=%h acc=%b expected %h acc=0", o2, acc, o);
            end
        end
        step(1, 16'h100, 16'h1, 4'd9, 0, 0, 0, 1, acc, xf, o);
        checks++;
        if (!xf || o.alu_out !== 16'd3 || acc !== 1) begin
            errs++; $display("FAIL bp_drain1 xf=%b r=%h acc=%b expected 1 0003 1", xf, o.alu_out, acc);
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, acc, xf, o);
        checks++;
        if (!xf || o.alu_out !== 16'h001E) begin errs++; $display("FAIL bp_drain2 xf=%b r=%h expected 1 001e", xf, o.alu_out); end
        step(0, 0, 0, 0, 0, 0, 0, 1, acc, xf, o);
        checks++;
        if (!xf || o.alu_out !== 16'h0101) begin errs++; $display("FAIL bp_drain3 xf=%b r=%h expected 1 0101", xf, o.alu_out); end
        step(1, 16'hFFFF, 16'h0001, 4'd9, 0, 0, 0, 0, acc, xf, o);
        step(1, 16'h0001, 16'h0001, 4'd9, 0, 0, 0, 0, acc, xf, o);
        #3;
        rst = 0;
        #1;
        checks++;
        if (out_valid !== 0 || in_ready !== 0) begin
            errs++; $display("FAIL bp_async_reset out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        in_valid = 0;
        #2;
        rst = 1;
        @(posedge clk);
        #1;
        run_op(16'h0000, 16'h0000, 4'd9, 0, 0, 1, o, got);
        checks++;
        if (!got || o.alu_out !== 16'h0000 || o.carry_out !== 0 || o.zero !== 1) begin
            errs++; $display("FAIL bp_sticky_cleared got=%b r=%h c=%b z=%b expected 1 0000 0 1", got, o.alu_out, o.carry_out, o.zero);
        end
    endtask

    task automatic test_random;
        logic acc, xf, v, m, ci, ch, rdy;
        logic [W-1:0] a, b;
        logic [3:0] sel;
        obs_t o;
        exp_t e, g;
        int n;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 5) == 0) ? 16'hFFFF : W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? a : W'($urandom);
            sel = 4'($urandom);
            m = 1'($urandom);
            ci = 1'($urandom);
            ch = 1'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            step(v, a, b, sel, m, ci, ch, rdy, acc, xf, o);
            if (xf) begin
                g = '{o.alu_out, o.carry_out, o.compare, o.zero, o.negative, o.overflow};
                e = (q.size() != 0) ? q.pop_front() : 'x;
                checks++;
                if (g !== e) begin errs++; $display("FAIL rand_result cycle=%0d got=%h expected=%h", i, g, e); end
            end
            if (acc) begin
                e = model(a, b, sel, m, ch ? msticky : ci);
                if (!m) msticky = e.c;
                q.push_back(e);
            end
        end
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, acc, xf, o);
            if (xf) begin
                g = '{o.alu_out, o.carry_out, o.compare, o.zero, o.negative, o.overflow};
                e = q.pop_front();
                checks++;
                if (g !== e) begin errs++; $display("FAIL rand_drain got=%h expected=%h", g, e); end
            end
            n++;
        end
        checks++;
        if (q.size() != 0) begin errs++; $display("FAIL rand_lost pending=%0d expected 0", q.size()); end
    endtask

    initial begin
        #3;
        test_reset();
        test_add();
        test_chain();
        test_overflow();
        test_logic_compare();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the 16-bit combinational ALU.
- Same mode/select function encoding, with WIDTH-generic datapath.
- Adds valid/ready handshakes on both sides, registered result flags (zero, negative, overflow, compare), and a sticky carry register for multi-word chained arithmetic.
- Sits between the register-file read stage and writeback; accepts one operation per cycle at full throughput.

Parameters:
- WIDTH, 16, datapath width in bits (>= 2).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  block can accept operation this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- select  input  4  function select
- mode  input  1  1 = logic, 0 = arithmetic
- carry_in  input  1  external carry, used when chain = 0
- chain  input  1  1 = use sticky carry register instead of carry_in
- out_valid  output  1  result valid
- out_ready  input  1  downstream consumes result
- alu_out  output  WIDTH  result
- carry_out  output  1  carry of arithmetic op; 0 in logic mode
- compare  output  1  A == B
- zero  output  1  alu_out == 0
- negative  output  1  alu_out[WIDTH-1]
- overflow  output  1  signed overflow; 0 in logic mode

Behaviour:
- Reset (rst low, asynchronous): s1_valid = 0, s2_valid = 0, sticky carry = 0. All outputs are 0, except in_ready = 1 once rst is high.
- Stage 1 register: captures in_a, in_b, select, mode, carry_in, chain on accept (in_valid && in_ready).
- Stage 2 register: computes from stage 1 and holds the result and flags.
- Handshake:
  - Advance = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || advance (combinational, no dependency on in_valid).
  - s2 loads on advance.
  - s2_valid clears on out_ready && s2_valid && !advance.
  - Outputs are held stable while out_valid && !out_ready.
- Latency: 2 cycles from the accept edge to out_valid. Throughput is 1 op per cycle when out_ready = 1. Ordering is strictly FIFO and no op is lost or duplicated.
- Effective carry: cin = chain ? sticky : carry_in. It is sampled at the advance edge from the current sticky value.
- Logic mode (mode = 1), result by select:
  - 0 ~A; 1 ~(A|B); 2 ~A&B; 3 zero; 4 ~(A&B); 5 ~B; 6 A^B; 7 A&~B
  - 8 ~A|B; 9 ~(A^B); 10 B; 11 A&B; 12 all-ones; 13 A|~B; 14 A|B; 15 A
  - cin is ignored; carry_out = 0, overflow = 0; sticky is unchanged.
- Arithmetic mode (mode = 0): S = X + Y + cin, computed at WIDTH+1 bits. alu_out = S[WIDTH-1:0], carry_out = S[WIDTH]. Operands X, Y by select:
  - 0: A, 0
  - 1: A|B, 0
  - 2: A|~B, 0
  - 3: 0, ones
  - 4: A, A&~B
  - 5: A|B, A&~B
  - 6: A, ~B
  - 7: A&~B, ones
  - 8: A, A&B
  - 9: A, B
  - 10: A|~B, A&B
  - 11: A&B, ones
  - 12: A, A
  - 13: A|B, A
  - 14: A|~B, A
  - 15: A, ones
- Overflow: overflow = (X[msb] == Y[msb]) && (S[msb] != X[msb]).
- Sticky carry: loaded with S[WIDTH] on each advance of an arithmetic-mode op, whether or not that op chained.
- Chained op immediately behind its producer: no hazard. The producer's sticky update occurs at its advance edge, and the consumer advances at a later edge.
- compare is evaluated on the stage-1 operands and registered with the result. zero and negative are derived from the registered result.
- Reset mid-operation: in-flight ops are discarded, valids clear immediately (asynchronous), sticky = 0.

Test Plan:
- Reset: hold rst low with in_valid = 1 -> out_valid = 0, alu_out = 0, all flags 0. After release, in_ready = 1.
- Add, WIDTH = 16: mode 0, select 9, A = 0x1234, B = 0x0001, carry_in = 0 -> alu_out = 0x1235 two cycles after accept; carry_out = 0, zero = 0.
- 32-bit chain:
  - op1 A = 0xFFFF, B = 0x0001, chain = 0, carry_in = 0 -> alu_out 0x0000, carry_out 1, zero 1.
  - op2 back-to-back, A = 0x0000, B = 0x0000, chain = 1 -> alu_out 0x0001, carry_out 0.
- Overflow: select 9, A = 0x7FFF, B = 0x0001 -> 0x8000, overflow 1, negative 1, carry_out 0. Then select 6, A = 0x0005, B = 0x0003, cin 1 -> 0x0002, carry_out 1.
- Logic plus compare: mode 1, select 6, A = 0xF0F0, B = 0xFF00 -> 0x0FF0, carry_out 0, compare 0. Select 15, A = B = 0xAAAA -> 0xAAAA, compare 1.
- Backpressure:
  - out_ready = 0, present 3 ops -> only 2 accepted, in_ready = 0 on the third, outputs stable.
  - Raise out_ready -> results emerge in order, one per cycle, third op accepted.
  - Assert rst mid-stream -> out_valid drops immediately, sticky = 0.
